// File: rtl/hash_light_pkg.sv
// Shared types and helpers for the streaming light hash.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package hash_light_pkg;

  localparam int DIGEST_BYTES_DEF = 4;
  localparam int ROUNDS_DEF       = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WAIT  = 3'd1;
  localparam state_t S_ROUND = 3'd2;
  localparam state_t S_PAD   = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  // Rotate a byte left by n bit positions (n = 0..7).
  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Per-round constant: the round index itself, already truncated to a byte.
  function automatic logic [7:0] rc(input logic [7:0] idx);
    return idx;
  endfunction

endpackage

// File: rtl/hash_light_round.sv
// One combinational compression round: H'[i] = rotl8(H[i+1] ^ M, i%7+1) ^ rc(r).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
module hash_light_round
  import hash_light_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEF
) (
  input  logic [DIGEST_BYTES*8-1:0] h_in,
  input  logic [7:0]                m,
  input  logic [7:0]                r,
  output logic [DIGEST_BYTES*8-1:0] h_out
);

  // Every output byte is built from the old state only, so all bytes update together.
  always_comb begin
    h_out = '0;
    for (int i = 0; i < DIGEST_BYTES; i++) begin
      h_out[8*i +: 8] = rotl8(h_in[8*((i+1) % DIGEST_BYTES) +: 8] ^ m, 3'((i % 7) + 1)) ^ rc(r);
    end
  end

endmodule

// File: rtl/hash_light_stream.sv
// Streaming light hash: absorbs bytes over valid/ready into an IV-seeded state; optional length pad (HASH_LIGHT_LEN_PAD_EN).
// Latency: ROUNDS cycles per accepted byte (plus ROUNDS for the pad byte when enabled), then a one-cycle done pulse.
// Backpressure: msg_ready is high only while waiting for a byte; it drops for the whole round sequence of each byte.
module hash_light_stream
  import hash_light_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_DEF,
  parameter int ROUNDS       = ROUNDS_DEF,
  parameter int LEN_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIGEST_BYTES*8-1:0] iv,
  input  logic                      msg_valid,
  input  logic [7:0]                msg_data,
  input  logic                      msg_last,
  output logic                      msg_ready,
  output logic [DIGEST_BYTES*8-1:0] digest,
  output logic                      done,
  output logic                      busy,
  output logic [LEN_W-1:0]          byte_count
);

  localparam int          DW     = DIGEST_BYTES * 8;
  localparam logic [7:0]  LAST_R = 8'(ROUNDS - 1);

  state_t            state_q, state_d;
  logic [DW-1:0]     h_q, h_d;
  logic [7:0]        m_q, m_d;
  logic [7:0]        r_q, r_d;
  logic              last_q, last_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              start_acc;
  logic [DW-1:0]     h_round;

  hash_light_round #(.DIGEST_BYTES(DIGEST_BYTES)) u_round (
    .h_in  (h_q),
    .m     (m_q),
    .r     (r_q),
    .h_out (h_round)
  );

  // Next-state logic: start edge detect, byte handshake, round sequencing.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    r_d     = r_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    start_d = start;
    // A held start cannot retrigger; edges are only honoured when no hash is running.
    start_acc = start && !start_q && (state_q == S_IDLE || state_q == S_DONE);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_acc) begin
          h_d     = iv;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (msg_valid) begin
          m_d     = msg_data;
          last_d  = msg_last;
          r_d     = '0;
          state_d = S_ROUND;
          if (cnt_q != '1) cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_ROUND: begin
        h_d = h_round;
        r_d = r_q + 8'd1;
        if (r_q == LAST_R) begin
          if (!last_q) begin
            state_d = S_WAIT;
          end else begin
`ifdef HASH_LIGHT_LEN_PAD_EN
            // Pad byte is the low byte of the message length; it is not counted.
            m_d     = 8'(cnt_q);
            r_d     = '0;
            state_d = S_PAD;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef HASH_LIGHT_LEN_PAD_EN
      S_PAD: begin
        h_d = h_round;
        r_d = r_q + 8'd1;
        if (r_q == LAST_R) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears everything including the start edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      r_q     <= r_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign digest     = h_q;
  assign byte_count = cnt_q;
  assign msg_ready  = (state_q == S_WAIT);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q == S_WAIT) || (state_q == S_ROUND) || (state_q == S_PAD);

endmodule
